// File: rtl/pll_reset_pkg.sv
// Shared types for the PLL reset sequencer.
// State encoding, domain indices and the state-to-reset decode.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    REL0,
    REL1,
    RUN
  } seq_state_t;

  localparam int unsigned DOM_W   = 3;
  localparam int unsigned DOM_CPU = 0;
  localparam int unsigned DOM_VID = 1;
  localparam int unsigned DOM_AUD = 2;

  function automatic logic [DOM_W-1:0] dom_of(
    input seq_state_t s
  );
    logic [DOM_W-1:0] d;
    d = '0;
    unique case (s)
      REL0: begin
        d[DOM_CPU] = 1'b1;
      end
      REL1: begin
        d[DOM_CPU] = 1'b1;
        d[DOM_VID] = 1'b1;
      end
      RUN: begin
        d[DOM_CPU] = 1'b1;
        d[DOM_VID] = 1'b1;
        d[DOM_AUD] = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer for the asynchronous PLL lock flag.
// Cleared to 0 so a fresh reset always reads as "not locked".
module pll_lock_sync
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_STAGES-1:0] r_sync;

  // shift the async input through the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Releases CPU, video, audio/IO resets in order once PLL lock
// is stable; lock loss or soft reset re-asserts them.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  output logic [DOM_W-1:0]      dom_rst_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX =
    (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int unsigned CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(STAGE_GAP - 1);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_loss_inc;
  logic                   w_lock_s;
  logic [DOM_W-1:0]       r_dom_rst_n;
  logic                   r_ready;
  logic [LOSS_CNT_W-1:0]  r_loss_cnt;

  pll_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pll_locked),
    .o_sync  (w_lock_s)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // next state and counter; lock loss beats soft reset beats expiry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_loss_inc  = 1'b0;
    unique case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = STABLE;
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = REL0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (soft_rst) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = REL0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      REL0: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (soft_rst) begin
          w_state_nxt = HOLD;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = REL1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      REL1: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (soft_rst) begin
          w_state_nxt = HOLD;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_loss_inc  = 1'b1;
        end else if (soft_rst) begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // state, counter and outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_dom_rst_n <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dom_rst_n <= dom_of(w_state_nxt);
      r_ready     <= (w_state_nxt == RUN);
    end
  end

  // saturating count of lock losses seen while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_inc && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign dom_rst_n     = r_dom_rst_n;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected outputs are
// queued with their due cycle and compared at the negedge.
module tb_pll_reset_seq;
  import pll_reset_pkg::*;

  localparam int unsigned SS = 2;
  localparam int unsigned LS = 8;
  localparam int unsigned SG = 4;
  localparam int unsigned LW = 2;

  typedef struct {
    int unsigned at;
    logic [2:0]  dom;
    logic        rdy;
    logic [1:0]  loss;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          soft_rst = 1'b0;
  logic [2:0]    dom_rst_n;
  logic          ready;
  logic [LW-1:0] lock_loss_cnt;

  int unsigned   cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  exp_t          sb[$];
  exp_t          e;
  int unsigned   c;

  pll_reset_seq #(
    .SYNC_STAGES (SS),
    .LOCK_STABLE (LS),
    .STAGE_GAP   (SG),
    .LOSS_CNT_W  (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_rst      (soft_rst),
    .dom_rst_n     (dom_rst_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned at,
                           input logic [2:0] d,
                           input logic r,
                           input logic [1:0] l,
                           input string tag);
    exp_t x;
    x.at = at; x.dom = d; x.rdy = r;
    x.loss = l; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic push_release(input int unsigned c0,
                              input logic [1:0] l);
    expect_at(c0 + 10, 3'b000, 1'b0, l, "pre_cpu");
    expect_at(c0 + 11, 3'b001, 1'b0, l, "rel_cpu");
    expect_at(c0 + 14, 3'b001, 1'b0, l, "pre_vid");
    expect_at(c0 + 15, 3'b011, 1'b0, l, "rel_vid");
    expect_at(c0 + 18, 3'b011, 1'b0, l, "pre_aud");
    expect_at(c0 + 19, 3'b111, 1'b1, l, "rel_aud");
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sat(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  // compare due expectations and monotonic ordering
  always @(negedge clk) begin
    if (rst_n) begin
      check("mono",
            32'(dom_rst_n inside {3'b000, 3'b001,
                                  3'b011, 3'b111}),
            32'd1);
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at != cyc) check({e.tag, "_late"}, cyc, e.at);
      check(e.tag,
            32'({dom_rst_n, ready, lock_loss_cnt}),
            32'({e.dom, e.rdy, e.loss}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_dom", 32'(dom_rst_n), 32'd0);
    check("rst_rdy", 32'(ready), 32'd0);
    check("rst_loss", 32'(lock_loss_cnt), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // clean lock
    c = cyc; pll_locked = 1'b1;
    push_release(c, 2'd0);
    step(24);

    // loss in RUN
    c = cyc; pll_locked = 1'b0;
    expect_at(c + 2, 3'b111, 1'b1, 2'd0, "loss_pre");
    expect_at(c + 3, 3'b000, 1'b0, 2'd1, "loss_hit");
    step(6);
    c = cyc; pll_locked = 1'b1;
    push_release(c, 2'd1);
    step(24);

    // one-cycle soft reset
    c = cyc; soft_rst = 1'b1;
    expect_at(c + 1,  3'b000, 1'b0, 2'd1, "sr_hit");
    expect_at(c + 4,  3'b000, 1'b0, 2'd1, "sr_pre0");
    expect_at(c + 5,  3'b001, 1'b0, 2'd1, "sr_rel0");
    expect_at(c + 8,  3'b001, 1'b0, 2'd1, "sr_pre1");
    expect_at(c + 9,  3'b011, 1'b0, 2'd1, "sr_rel1");
    expect_at(c + 12, 3'b011, 1'b0, 2'd1, "sr_pre2");
    expect_at(c + 13, 3'b111, 1'b1, 2'd1, "sr_rel2");
    step(1);
    soft_rst = 1'b0;
    step(16);

    // soft reset held ten cycles
    c = cyc; soft_rst = 1'b1;
    expect_at(c + 1,  3'b000, 1'b0, 2'd1, "srh_hit");
    expect_at(c + 13, 3'b000, 1'b0, 2'd1, "srh_pre0");
    expect_at(c + 14, 3'b001, 1'b0, 2'd1, "srh_rel0");
    expect_at(c + 17, 3'b001, 1'b0, 2'd1, "srh_pre1");
    expect_at(c + 18, 3'b011, 1'b0, 2'd1, "srh_rel1");
    expect_at(c + 21, 3'b011, 1'b0, 2'd1, "srh_pre2");
    expect_at(c + 22, 3'b111, 1'b1, 2'd1, "srh_rel2");
    step(10);
    soft_rst = 1'b0;
    step(16);

    // second loss, then a short lock glitch
    c = cyc; pll_locked = 1'b0;
    expect_at(c + 3, 3'b000, 1'b0, 2'd2, "loss2");
    step(6);
    c = cyc; pll_locked = 1'b1;
    expect_at(c + 3,  3'b000, 1'b0, 2'd2, "gl_a");
    expect_at(c + 6,  3'b000, 1'b0, 2'd2, "gl_b");
    expect_at(c + 11, 3'b000, 1'b0, 2'd2, "gl_c");
    expect_at(c + 20, 3'b000, 1'b0, 2'd2, "gl_d");
    step(5);
    pll_locked = 1'b0;
    step(20);
    check("gl_state", 32'(dut.r_state), 32'(WAIT_LOCK));

    // three more losses: counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      c = cyc; pll_locked = 1'b1;
      push_release(c, sat(2 + k));
      step(24);
      c = cyc; pll_locked = 1'b0;
      expect_at(c + 3, 3'b000, 1'b0, sat(3 + k), "sat");
      step(6);
    end

    // async reset in REL1 with the clock stopped
    c = cyc; pll_locked = 1'b1;
    expect_at(c + 11, 3'b001, 1'b0, 2'd3, "ar_rel0");
    expect_at(c + 15, 3'b011, 1'b0, 2'd3, "ar_rel1");
    expect_at(c + 16, 3'b011, 1'b0, 2'd3, "ar_in1");
    step(16);
    @(negedge clk);
    #1 clk_en = 1'b0;
    #20 rst_n = 1'b0;
    #1;
    check("ar_dom", 32'(dom_rst_n), 32'd0);
    check("ar_rdy", 32'(ready), 32'd0);
    check("ar_loss", 32'(lock_loss_cnt), 32'd0);
    #20 rst_n = 1'b1;
    #5;
    c = cyc;
    push_release(c, 2'd0);
    clk_en = 1'b1;
    step(24);

    for (int i = 0; i < 50 && sb.size() > 0; i++)
      @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
